// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 slice.
//   - CP0 register numbers (SR, Cause, EPC, PRId)
//   - ExcCode values
//   - SR / Cause field positions
//   - exception handler entry address
//   - small packing helpers used by the read mux and the EPC update
package cp0_pkg;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes
  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // SR field positions
  localparam int SR_IM_LSB = 10;
  localparam int SR_IM_MSB = 15;
  localparam int SR_EXL    = 1;
  localparam int SR_IE     = 0;

  // Cause field positions
  localparam int CAUSE_BD      = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;

  // Fetch redirect target when req is taken
  localparam logic [31:0] HANDLER_ENTRY = 32'h0000_4180;

  // Build the architectural SR word; unimplemented bits read as zero.
  function automatic logic [31:0] sr_pack(input logic [5:0] im,
                                          input logic       exl,
                                          input logic       ie);
    sr_pack = {16'h0000, im, 8'h00, exl, ie};
  endfunction

  // Build the architectural Cause word.
  function automatic logic [31:0] cause_pack(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc);
    cause_pack = {bd, 15'h0000, ip, 3'b000, exc, 2'b00};
  endfunction

  // Victim PC for EPC: back up to the branch when the faulting
  // instruction sits in a delay slot, then force word alignment.
  function automatic logic [31:0] epc_victim(input logic [31:0] pc,
                                             input logic        bd);
    logic [31:0] t;
    if (bd) begin
      t = pc - 32'd4;
    end else begin
      t = pc;
    end
    epc_victim = {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_if.sv
// cp0_if: M-stage <-> CP0 bundle.
//   master (pipeline side) drives the mtc0 / exception / interrupt inputs
//   and receives read_data, epc_out and req.
//   slave (cp0) is the mirror image.
interface cp0_if;
  logic        write_enable;  // mtc0 in M stage
  logic [4:0]  addr;          // CP0 register number
  logic [31:0] write_data;    // mtc0 data
  logic [31:0] pc;            // victim PC
  logic        bd;            // instruction is in a delay slot
  logic [4:0]  exc_code;      // 0 = no exception
  logic [5:0]  hw_int;        // external interrupt lines
  logic        exl_clear;     // eret in M stage
  logic [31:0] read_data;     // mfc0 value
  logic [31:0] epc_out;       // eret target
  logic        req;           // take exception/interrupt this cycle

  modport master (
    output write_enable, addr, write_data, pc, bd, exc_code, hw_int, exl_clear,
    input  read_data, epc_out, req
  );

  modport slave (
    input  write_enable, addr, write_data, pc, bd, exc_code, hw_int, exl_clear,
    output read_data, epc_out, req
  );
endinterface

// File: rtl/cp0.sv
// cp0: coprocessor 0 for the M stage.
//   Holds SR, Cause, EPC and PRId, serves mfc0/mtc0 and raises req for
//   exceptions and external interrupts.
// Ports:
//   clk    clock
//   reset  synchronous, active-high; clears every register
//   bus    cp0_if.slave (mtc0/mfc0, exception inputs, req, epc_out)
// Parameter:
//   PRID   constant returned for register 15
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_2024
) (
  input logic  clk,
  input logic  reset,
  cp0_if.slave bus
);

  // SR fields
  logic [5:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  // Cause fields
  logic        r_bd;
  logic [4:0]  r_exc_code;
  logic [5:0]  r_ip;
  // EPC
  logic [31:0] r_epc;

  logic        w_int_req;
  logic        w_exc_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;

  // Take decision: live hw_int lines, interrupt ahead of exception,
  // everything masked while EXL is set or reset is asserted.
  always_comb begin
    w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
    w_exc_req = (bus.exc_code != 5'd0) & ~r_exl;
    w_req     = (w_int_req | w_exc_req) & ~reset;
    w_wr_sr   = bus.write_enable & (bus.addr == REG_SR);
    w_wr_epc  = bus.write_enable & (bus.addr == REG_EPC);
  end

  // Register update: reset, then taken req (mtc0 dropped), then mtc0/eret.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im       <= 6'd0;
      r_exl      <= 1'b0;
      r_ie       <= 1'b0;
      r_bd       <= 1'b0;
      r_exc_code <= 5'd0;
      r_ip       <= 6'd0;
      r_epc      <= 32'd0;
    end else begin
      r_ip <= bus.hw_int;
      if (w_req) begin
        r_exl      <= 1'b1;
        r_exc_code <= w_int_req ? EXC_INT : bus.exc_code;
        r_bd       <= bus.bd;
        r_epc      <= epc_victim(bus.pc, bus.bd);
      end else begin
        if (w_wr_sr) begin
          r_im <= bus.write_data[SR_IM_MSB:SR_IM_LSB];
          r_ie <= bus.write_data[SR_IE];
        end
        // eret overrides a same-cycle SR write of EXL
        if (bus.exl_clear) begin
          r_exl <= 1'b0;
        end else if (w_wr_sr) begin
          r_exl <= bus.write_data[SR_EXL];
        end
        if (w_wr_epc) begin
          r_epc <= bus.write_data;
        end
      end
    end
  end

  // mfc0 read mux from current state; a same-cycle mtc0 is not bypassed.
  always_comb begin
    bus.read_data = 32'd0;
    case (bus.addr)
      REG_SR:    bus.read_data = sr_pack(r_im, r_exl, r_ie);
      REG_CAUSE: bus.read_data = cause_pack(r_bd, r_ip, r_exc_code);
      REG_EPC:   bus.read_data = r_epc;
      REG_PRID:  bus.read_data = PRID;
      default:   bus.read_data = 32'd0;
    endcase
  end

  // Outputs to the pipeline.
  always_comb begin
    bus.epc_out = r_epc;
    bus.req     = w_req;
  end

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: directed, table-driven bench for cp0.
// Each vector is applied after a negedge and outputs are compared 1 ns
// later, i.e. well before the next posedge commits the cycle.
module tb_cp0;

  logic clk;
  logic reset;

  cp0_if bus_if();

  cp0 #(.PRID(32'h0000_2024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eclr;
    logic        exp_req;
    logic [31:0] exp_rd;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];
  int n_cmp;
  int n_bad;

  function automatic vec_t mk(input logic rst, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, input logic [31:0] pc,
                              input logic bd, input logic [4:0] exc, input logic [5:0] hw,
                              input logic eclr, input logic exp_req,
                              input logic [31:0] exp_rd, input logic [31:0] exp_epc);
    vec_t v;
    v.rst = rst; v.we = we; v.addr = addr; v.wdata = wdata; v.pc = pc; v.bd = bd;
    v.exc = exc; v.hw = hw; v.eclr = eclr; v.exp_req = exp_req;
    v.exp_rd = exp_rd; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset                = v.rst;
    bus_if.write_enable  = v.we;
    bus_if.addr          = v.addr;
    bus_if.write_data    = v.wdata;
    bus_if.pc            = v.pc;
    bus_if.bd            = v.bd;
    bus_if.exc_code      = v.exc;
    bus_if.hw_int        = v.hw;
    bus_if.exl_clear     = v.eclr;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    //           rst   we    addr   wdata          pc             bd    exc    hw         eclr  req   rd             epc
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 0 SR after reset
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 1 Cause
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 2 EPC
    vecs.push_back(mk(1'b0, 1'b0, 5'd15, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_2024, 32'h0));       // 3 PRId
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 4 mtc0 SR, no bypass
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0000_3010, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0));       // 5 interrupt taken
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0000_3014, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3010)); // 6 held line, EXL blocks
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0000_3018, 1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3010)); // 7 EXL=1
    vecs.push_back(mk(1'b0, 1'b1, 5'd14, 32'h0000_3100, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_3010)); // 8 eret + mtc0 EPC
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3100, 32'h0000_3100)); // 9
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0401, 32'h0000_3100)); // 10 EXL cleared
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0000_3020, 1'b1, 5'd12, 6'b000000, 1'b0, 1'b1, 32'h0,        32'h0000_3100)); // 11 Ov in delay slot
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0000_3024, 1'b0, 5'd12, 6'b000010, 1'b0, 1'b0, 32'h8000_0030, 32'h0000_301C)); // 12
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h8000_0830, 32'h0000_301C)); // 13 IP latched
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0403, 32'h0000_301C)); // 14 eret
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0000_3040, 1'b0, 5'd4,  6'b000001, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_301C)); // 15 int + AdEL
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3040)); // 16 ExcCode=Int
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_3040, 32'h0000_3040)); // 17 eret
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0000_3050, 1'b0, 5'd5,  6'b000000, 1'b0, 1'b1, 32'h0000_0401, 32'h0000_3040)); // 18 req + mtc0 SR
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3050)); // 19 mtc0 dropped
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0014, 32'h0000_3050)); // 20 AdES
    vecs.push_back(mk(1'b1, 1'b0, 5'd15, 32'h0,        32'h0000_3060, 1'b0, 5'd8,  6'b000001, 1'b0, 1'b0, 32'h0000_2024, 32'h0000_3050)); // 21 reset mid-handler
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 22
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 23
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 24
    vecs.push_back(mk(1'b0, 1'b1, 5'd20, 32'hDEAD_BEEF, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 25 other reg
    vecs.push_back(mk(1'b0, 1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 26 Cause write
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 27 Cause unchanged
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0,        32'h0));        // 28 SR all ones
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_FC03, 32'h0));        // 29 masked bits, EXL blocks
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 32'h0000_0403, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_FC03, 32'h0));        // 30 eret wins EXL
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0401, 32'h0));        // 31
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0000_3063, 1'b0, 5'd10, 6'b000000, 1'b0, 1'b1, 32'h0000_0401, 32'h0));        // 32 RI unaligned pc
    vecs.push_back(mk(1'b0, 1'b0, 5'd14, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_3060, 32'h0000_3060)); // 33 aligned EPC
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0028, 32'h0000_3060)); // 34 RI code
    vecs.push_back(mk(1'b0, 1'b0, 5'd13, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000000, 1'b1, 1'b0, 32'h0000_0028, 32'h0000_3060)); // 35 eret
    vecs.push_back(mk(1'b0, 1'b1, 5'd12, 32'h0000_0400, 32'h0,       1'b0, 5'd0,  6'b000000, 1'b0, 1'b0, 32'h0000_0401, 32'h0000_3060)); // 36 IE off
    vecs.push_back(mk(1'b0, 1'b0, 5'd12, 32'h0,        32'h0,        1'b0, 5'd0,  6'b000001, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3060)); // 37 IE=0 masks

    // Initial synchronous reset (state is unknown before this)
    drive(mk(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_req", {31'd0, bus_if.req}, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d_req", i), {31'd0, bus_if.req}, {31'd0, vecs[i].exp_req});
      check($sformatf("v%0d_rd",  i), bus_if.read_data, vecs[i].exp_rd);
      check($sformatf("v%0d_epc", i), bus_if.epc_out,   vecs[i].exp_epc);
    end

    // Hand sequence: IP latency vs live req decision, BD capture in Cause
    @(negedge clk);
    drive(mk(1'b1, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    drive(mk(1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    drive(mk(1'b0, 1'b0, 5'd13, 32'h0, 32'h0000_5004, 1'b1, 5'd0, 6'b000001, 1'b0, 1'b0, 32'h0, 32'h0));
    #1;
    check("seq_live_req", {31'd0, bus_if.req}, 32'd1);
    check("seq_ip_lag",   bus_if.read_data, 32'h0);
    @(negedge clk);
    drive(mk(1'b0, 1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 5'd0, 6'b000000, 1'b0, 1'b0, 32'h0, 32'h0));
    #1;
    check("seq_req_low",  {31'd0, bus_if.req}, 32'd0);
    check("seq_cause",    bus_if.read_data, 32'h8000_0400);
    check("seq_epc_bd",   bus_if.epc_out,   32'h0000_5000);
    @(negedge clk);
    #1;
    check("seq_ip_drop",  bus_if.read_data, 32'h8000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 for the M stage of the pipelined MIPS core. Holds SR, Cause, EPC and PRId, serves mfc0/mtc0, and raises `req` for exceptions and external interrupts. `req` flushes the pipeline registers, including the M→W register, and redirects fetch to the handler. `read_data` is the M-stage value latched into the W stage for mfc0.

## Interface
- `PRID`, default 32'h0000_2024, constant returned for register 15.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `write_enable`  in  1  mtc0 in M stage (already gated by the exception path).
- `addr`  in  5  CP0 register number, rd field.
- `write_data`  in  32  mtc0 data (rt, forwarded).
- `pc`  in  32  PC of the M-stage instruction (victim PC).
- `bd`  in  1  M-stage instruction is in a delay slot.
- `exc_code`  in  5  exception code from E/M checks; 0 = none.
- `hw_int`  in  6  external interrupt lines (timer0, timer1, interrupt generator, unused).
- `exl_clear`  in  1  eret in M stage.
- `read_data`  out  32  mfc0 read value.
- `epc_out`  out  32  current EPC, used as the eret target.
- `req`  out  1  take exception/interrupt this cycle.

## Operation
- SR (12): IM[15:10], EXL[1], IE[0]. Other bits read as 0 and are not writable.
- Cause (13):
  - BD[31] and ExcCode[6:2] are updated only on `req`.
  - IP[15:10] is loaded from `hw_int` every cycle.
  - Cause is not writable by mtc0.
- EPC (14): fully writable by mtc0 and loaded on `req`.
- PRId (15): reads `PRID` and is read-only.
- Any other `addr` reads 0. Writes to it are ignored.
- `int_req` = |(IP_next & SR.IM) & SR.IE & !SR.EXL, where IP_next = `hw_int`, i.e. the live lines.
- `exc_req` = (`exc_code` != 0) & !SR.EXL.
- `req` = (`int_req` | `exc_req`) & !`reset`.
- Interrupt has priority over exception. On interrupt, ExcCode = 0 (Int).
- Posedge update, in priority order:
  1. `reset`: every register is 0.
  2. `req`:
     - EXL ← 1.
     - ExcCode ← (`int_req` ? 0 : `exc_code`).
     - BD ← `bd`.
     - EPC ← `bd` ? `pc`−4 : `pc`, taken as {addr[31:2],2'b00}, i.e. word-aligned.
     - A concurrent mtc0 is discarded.
  3. Otherwise:
     - mtc0 to 12 writes the IM/EXL/IE masks.
     - mtc0 to 14 writes EPC.
     - `exl_clear` clears EXL, after any SR write in the same cycle. eret wins on EXL.
- `read_data` is combinational from the current register state. No bypass of the same-cycle write.
- `epc_out` = EPC register, combinational.
- ExcCode values: Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12.

## Timing
- `req` is combinational in the same cycle as the faulting instruction or the interrupt line. Register effects are visible after the next posedge.
- mtc0 result is readable by mfc0 from the following cycle.
- IP reflects `hw_int` with 1-cycle latency when read. The `req` decision uses live `hw_int`.
- While EXL=1, `req` = 0 regardless of `exc_code`/`hw_int`, so there are no nested exceptions.
- Reset asserted mid-handler: EXL, EPC and Cause clear at that edge. `req` is low throughout reset.
- `req` coincident with `exl_clear`: impossible as a taken `req`, since EXL=1 blocks it. If EXL=0, `exl_clear` is a no-op and `req` proceeds.
- Reset values: `read_data` = 0 for 12/13/14, `PRID` for 15; `epc_out` = 0; `req` = 0.

## Structure
- Shared package `cp0_pkg`:
  - register numbers 12/13/14/15;
  - ExcCode constants;
  - SR/Cause bit positions;
  - handler entry 32'h0000_4180.
- No sub-module is natural. Single always block for state, plus combinational req/read logic.

## Test plan
- Reset, then mfc0 12/13/14/15 → 0, 0, 0, 32'h0000_2024; `req` = 0.
- mtc0 12 ← 32'h0000_0401; `hw_int` = 6'b000001 → `req` = 1 next cycle. Then:
  - EXL = 1, ExcCode = 0.
  - EPC = `pc`, e.g. 32'h0000_3010.
  - `req` stays 0 while the line is held.
- `exc_code` = 12 (Ov), `bd` = 1, `pc` = 32'h0000_3020 → `req` = 1. Then:
  - EPC = 32'h0000_301C.
  - Cause = 32'h8000_0030, plus the IP bits.
- Same cycle: `exc_code` = 4 and `hw_int` enabled with IE = 1 → ExcCode = 0 (interrupt priority).
- EXL = 1 with `exl_clear` = 1 → SR.EXL = 0 next cycle. mtc0 14 ← 32'h0000_3100 in that cycle → `epc_out` = 32'h0000_3100.
- Cycle with both `req` and mtc0 12 ← 32'hFFFF_FFFF → SR keeps its old IM/IE with EXL = 1. Asserting `reset` afterwards → all registers 0.
